// File: rtl/mas_alu_issue_queue.sv
// mas_alu_issue_queue: in-order command FIFO and single-outstanding issuer for
// mas_alu_top. Commands wait in a small FIFO, go to the ALU one at a time on a
// req/ready handshake, and each result (or a timeout marker) is presented on a
// valid/ready output port before the next command is issued.
module mas_alu_issue_queue #(
   parameter int MAS_BLEN = 32,
   parameter int CMD_W    = 3,
   parameter int DEPTH    = 4,
   parameter int TIMEOUT  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CMD_W-1:0]             in_cmd,
   input  logic [MAS_BLEN-1:0]          in_op1,
   input  logic [MAS_BLEN-1:0]          in_op2,
   output logic                         mas_alu_req,
   output logic [CMD_W-1:0]             mas_alu_cmd,
   output logic [MAS_BLEN-1:0]          mas_alu_op1,
   output logic [MAS_BLEN-1:0]          mas_alu_op2,
   input  logic                         mas_alu_ready,
   input  logic [MAS_BLEN-1:0]          mas_alu_res,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [MAS_BLEN-1:0]          out_res,
   output logic [CMD_W-1:0]             out_cmd,
   output logic                         out_timeout,
   output logic [$clog2(DEPTH+1)-1:0]   q_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam int ENT_W = CMD_W + 2*MAS_BLEN;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   // FIFO storage: plain array so it can map onto distributed/block RAM.
   logic [ENT_W-1:0]     mem_reg [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [CNT_W-1:0]     count_reg;

   state_t               state_reg, state_next;
   logic [TMR_W-1:0]     timer_reg, timer_next;

   // Command currently owned by the issuer; drives the ALU directly.
   logic [CMD_W-1:0]     cmd_reg;
   logic [MAS_BLEN-1:0]  op1_reg;
   logic [MAS_BLEN-1:0]  op2_reg;

   logic                 out_valid_reg, out_valid_next;
   logic [MAS_BLEN-1:0]  out_res_reg;
   logic [CMD_W-1:0]     out_cmd_reg;
   logic                 out_timeout_reg;

   logic                 push;
   logic                 pop;
   logic                 capture_res;
   logic                 capture_to;

   // Acceptance looks at occupancy only, so a full FIFO refuses even while popping.
   assign in_ready = (count_reg < CNT_W'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (state_reg == IDLE) && (count_reg != '0);

   assign mas_alu_req = (state_reg == REQ);
   assign mas_alu_cmd = cmd_reg;
   assign mas_alu_op1 = op1_reg;
   assign mas_alu_op2 = op2_reg;
   assign out_valid   = out_valid_reg;
   assign out_res     = out_res_reg;
   assign out_cmd     = out_cmd_reg;
   assign out_timeout = out_timeout_reg;
   assign q_count     = count_reg;

   // Write side of the FIFO storage (no reset needed on the data itself).
   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= {in_cmd, in_op1, in_op2};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Issue FSM next-state: the timer gates out a stale ready left over from the previous op.
   always_comb begin
      state_next     = state_reg;
      timer_next     = timer_reg;
      out_valid_next = out_valid_reg;
      capture_res    = 1'b0;
      capture_to     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0) begin
               state_next = REQ;
               timer_next = '0;
            end
         end
         REQ: begin
            timer_next = timer_reg + TMR_W'(1);
            if ((timer_reg != '0) && mas_alu_ready) begin
               capture_res    = 1'b1;
               out_valid_next = 1'b1;
               state_next     = RESP;
            end else if (timer_reg == TMR_W'(TIMEOUT-1)) begin
               capture_to     = 1'b1;
               out_valid_next = 1'b1;
               state_next     = RESP;
            end
         end
         RESP: begin
            if (out_ready) begin
               out_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM state, issued-command registers and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         timer_reg       <= '0;
         cmd_reg         <= '0;
         op1_reg         <= '0;
         op2_reg         <= '0;
         out_valid_reg   <= 1'b0;
         out_res_reg     <= '0;
         out_cmd_reg     <= '0;
         out_timeout_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         timer_reg     <= timer_next;
         out_valid_reg <= out_valid_next;
         if (pop) begin
            {cmd_reg, op1_reg, op2_reg} <= mem_reg[rd_ptr_reg];
         end
         if (capture_res) begin
            out_res_reg     <= mas_alu_res;
            out_cmd_reg     <= cmd_reg;
            out_timeout_reg <= 1'b0;
         end else if (capture_to) begin
            out_res_reg     <= '0;
            out_cmd_reg     <= cmd_reg;
            out_timeout_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mas_alu_issue_queue.sv
// Testbench for mas_alu_issue_queue: the bench plays upstream, ALU and consumer.
// A transaction-level model (FIFO of pushed commands, per-command ALU latency,
// expected outcome derived from the ready/timeout rules) checks every cycle.
module tb_mas_alu_issue_queue;
   localparam int MAS_BLEN = 32;
   localparam int CMD_W    = 3;
   localparam int DEPTH    = 4;
   localparam int TIMEOUT  = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [CMD_W-1:0]     in_cmd;
   logic [MAS_BLEN-1:0]  in_op1;
   logic [MAS_BLEN-1:0]  in_op2;
   logic                 mas_alu_req;
   logic [CMD_W-1:0]     mas_alu_cmd;
   logic [MAS_BLEN-1:0]  mas_alu_op1;
   logic [MAS_BLEN-1:0]  mas_alu_op2;
   logic                 mas_alu_ready;
   logic [MAS_BLEN-1:0]  mas_alu_res;
   logic                 out_valid;
   logic                 out_ready;
   logic [MAS_BLEN-1:0]  out_res;
   logic [CMD_W-1:0]     out_cmd;
   logic                 out_timeout;
   logic [2:0]           q_count;

   always #5 clk = ~clk;

   mas_alu_issue_queue #(
      .MAS_BLEN (MAS_BLEN),
      .CMD_W    (CMD_W),
      .DEPTH    (DEPTH),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_cmd        (in_cmd),
      .in_op1        (in_op1),
      .in_op2        (in_op2),
      .mas_alu_req   (mas_alu_req),
      .mas_alu_cmd   (mas_alu_cmd),
      .mas_alu_op1   (mas_alu_op1),
      .mas_alu_op2   (mas_alu_op2),
      .mas_alu_ready (mas_alu_ready),
      .mas_alu_res   (mas_alu_res),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_res       (out_res),
      .out_cmd       (out_cmd),
      .out_timeout   (out_timeout),
      .q_count       (q_count)
   );

   // wt = number of request cycles the bench ALU lets pass before raising ready
   // (ready is shown on request cycle wt+1); negative means it never answers.
   typedef struct {
      logic [CMD_W-1:0]    cmd;
      logic [MAS_BLEN-1:0] op1;
      logic [MAS_BLEN-1:0] op2;
      int                  wt;
   } item_t;

   typedef struct {
      logic [CMD_W-1:0]    cmd;
      logic [MAS_BLEN-1:0] res;
      logic                tmo;
      int                  reqcyc;
   } exp_t;

   item_t push_q[$];
   exp_t  exp_q[$];
   item_t cur;
   int    in_wt;
   int    req_cnt;
   logic  req_prev;
   bit    alu_hold;
   bit    last_acc;
   int    errors = 0;
   int    checks = 0;
   int    wt_tab[7] = '{-1, 0, 1, 2, 3, 5, 15};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // The bench ALU's arithmetic.
   function automatic logic [MAS_BLEN-1:0] alu_f(input logic [CMD_W-1:0] c,
                                                 input logic [MAS_BLEN-1:0] a,
                                                 input logic [MAS_BLEN-1:0] b);
      case (c)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << b[4:0];
         3'd6:    return a >> b[4:0];
         default: return (a < b) ? 32'd1 : 32'd0;
      endcase
   endfunction

   // Outcome of one command: a ready on request cycle k is seen only when
   // k-1 (cycles already spent) is between 1 and TIMEOUT-1; otherwise it times
   // out after TIMEOUT request cycles with a zero result.
   function automatic exp_t predict(input item_t it, input bit hold);
      exp_t e;
      e.cmd = it.cmd;
      if (hold) begin
         e.res = alu_f(it.cmd, it.op1, it.op2);
         e.tmo = 1'b0;
         e.reqcyc = 2;
      end else if (it.wt >= 1 && it.wt <= TIMEOUT-1) begin
         e.res = alu_f(it.cmd, it.op1, it.op2);
         e.tmo = 1'b0;
         e.reqcyc = it.wt + 1;
      end else begin
         e.res = '0;
         e.tmo = 1'b1;
         e.reqcyc = TIMEOUT;
      end
      return e;
   endfunction

   // One clock cycle: settle handshakes, update the model, check, drive the ALU.
   task automatic cyc();
      item_t it;
      exp_t  e;
      bit    acc;
      bit    fire;
      acc = in_valid && (push_q.size() < DEPTH);
      last_acc = acc;
      chk("in_ready", 64'(in_ready), 64'(push_q.size() < DEPTH));
      fire = out_valid && out_ready;
      if (fire) begin
         chk("result_pending", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_timeout", 64'(out_timeout), 64'(e.tmo));
            chk("out_res", 64'(out_res), 64'(e.res));
            if (!e.tmo) chk("out_cmd", 64'(out_cmd), 64'(e.cmd));
            $display("result: cmd=%0d res=%08h timeout=%0b", out_cmd, out_res, out_timeout);
         end
      end
      it.cmd = in_cmd;
      it.op1 = in_op1;
      it.op2 = in_op2;
      it.wt  = in_wt;
      @(posedge clk);
      #1;
      if (acc) push_q.push_back(it);
      if (mas_alu_req) begin
         req_cnt++;
         if (req_cnt == 1) begin
            chk("issue_from_nonempty", 64'(push_q.size() != 0), 64'(1));
            if (push_q.size() != 0) begin
               cur = push_q.pop_front();
               chk("alu_cmd", 64'(mas_alu_cmd), 64'(cur.cmd));
               chk("alu_ops", {mas_alu_op1, mas_alu_op2}, {cur.op1, cur.op2});
               exp_q.push_back(predict(cur, alu_hold));
            end
         end else begin
            chk("alu_cmd_stable", 64'(mas_alu_cmd), 64'(cur.cmd));
            chk("alu_ops_stable", {mas_alu_op1, mas_alu_op2}, {cur.op1, cur.op2});
         end
      end else begin
         if (req_prev && exp_q.size() != 0) begin
            chk("req_cycles", 64'(req_cnt), 64'(exp_q[$].reqcyc));
            chk("out_valid_after_req", 64'(out_valid), 64'(1));
         end
         req_cnt = 0;
      end
      req_prev = mas_alu_req;
      chk("q_count", 64'(q_count), 64'(push_q.size()));
      chk("q_count_max", 64'(q_count <= 3'(DEPTH)), 64'(1));
      chk("req_and_valid", 64'(mas_alu_req && out_valid), 64'(0));
      mas_alu_ready = alu_hold || (mas_alu_req && (req_cnt == cur.wt + 1));
      mas_alu_res   = (mas_alu_req && mas_alu_ready) ? alu_f(cur.cmd, cur.op1, cur.op2)
                                                     : MAS_BLEN'($urandom);
   endtask

   // Present one command and hold it until accepted (caller drops in_valid).
   task automatic push_item(input logic [CMD_W-1:0] c, input logic [MAS_BLEN-1:0] a,
                            input logic [MAS_BLEN-1:0] b, input int wt, input int budget);
      in_valid = 1'b1;
      in_cmd   = c;
      in_op1   = a;
      in_op2   = b;
      in_wt    = wt;
      last_acc = 1'b0;
      for (int i = 0; i < budget; i++) begin
         cyc();
         if (last_acc) break;
      end
      chk("push_accepted", 64'(last_acc), 64'(1));
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && !out_valid; i++) cyc();
      chk("wait_out_valid", 64'(out_valid), 64'(1));
   endtask

   task automatic drain(input int budget);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (push_q.size() == 0 && exp_q.size() == 0 && !mas_alu_req && !out_valid) break;
         cyc();
      end
      chk("drain_done", 64'(push_q.size() == 0 && exp_q.size() == 0 && !mas_alu_req && !out_valid),
          64'(1));
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_cmd = '0;
      in_op1 = '0;
      in_op2 = '0;
      in_wt = 0;
      out_ready = 1'b1;
      mas_alu_ready = 1'b0;
      mas_alu_res = '0;
      alu_hold = 1'b0;
      req_cnt = 0;
      req_prev = 1'b0;
      cur = '{default: 0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 64'(mas_alu_req), 64'(0));
      chk("rst_q_count", 64'(q_count), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_res", 64'(out_res), 64'(0));
      chk("rst_out_timeout", 64'(out_timeout), 64'(0));
      chk("rst_alu_op1", 64'(mas_alu_op1), 64'(0));
      rst = 1'b0;

      // Single op: ADD 5,7, ready on the third request cycle, consumer stalls a while
      out_ready = 1'b0;
      push_item(3'd0, 32'd5, 32'd7, 2, 4);
      in_valid = 1'b0;
      chk("no_bypass", 64'(mas_alu_req), 64'(0));
      cyc();
      chk("issue_latency", 64'(mas_alu_req), 64'(1));
      wait_valid(20);
      chk("single_res", 64'(out_res), 64'(12));
      chk("single_timeout", 64'(out_timeout), 64'(0));
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("single_hold_valid", 64'(out_valid), 64'(1));
      end
      out_ready = 1'b1;
      cyc();
      chk("single_valid_drop", 64'(out_valid), 64'(0));

      // Full: stream of back-to-back pushes against a slow ALU
      for (int i = 0; i < 6; i++) begin
         push_item(3'($urandom), $urandom, $urandom, 5, 40);
      end
      in_valid = 1'b0;
      drain(500);

      // Stale ready: ALU ready held high the whole time
      alu_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_item(3'($urandom), $urandom, $urandom, 0, 40);
      end
      in_valid = 1'b0;
      drain(200);
      alu_hold = 1'b0;

      // Timeout, then a normal minimum-latency op
      push_item(3'd1, 32'd100, 32'd1, -1, 4);
      in_valid = 1'b0;
      wait_valid(40);
      chk("timeout_flag", 64'(out_timeout), 64'(1));
      chk("timeout_res", 64'(out_res), 64'(0));
      drain(50);
      push_item(3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 4);
      in_valid = 1'b0;
      wait_valid(20);
      chk("after_timeout_res", 64'(out_res), 64'(32'hFF00_FF00));
      chk("after_timeout_flag", 64'(out_timeout), 64'(0));
      drain(50);

      // Backpressure: result held, FIFO keeps filling, no new request
      out_ready = 1'b0;
      push_item(3'd0, 32'd1, 32'd2, 2, 4);
      in_valid = 1'b0;
      wait_valid(20);
      for (int i = 0; i < 4; i++) begin
         push_item(3'($urandom), $urandom, $urandom, 3, 4);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("bp_valid", 64'(out_valid), 64'(1));
         chk("bp_no_req", 64'(mas_alu_req), 64'(0));
      end
      chk("bp_q_full", 64'(q_count), 64'(DEPTH));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      drain(200);

      // Ready on the last allowed cycle beats the timeout
      push_item(3'd3, 32'h0000_00A0, 32'h0000_000B, TIMEOUT-1, 4);
      in_valid = 1'b0;
      wait_valid(40);
      chk("ready_beats_timeout", 64'(out_timeout), 64'(0));
      chk("ready_beats_res", 64'(out_res), 64'(32'h0000_00AB));
      drain(20);
      // Ready only during the first request cycle is stale and must be ignored
      push_item(3'd2, $urandom, $urandom, 0, 4);
      in_valid = 1'b0;
      drain(50);

      // Randomized traffic with random per-command latency and consumer stalls
      for (int i = 0; i < 250; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_cmd    = 3'($urandom);
         in_op1    = $urandom;
         in_op2    = $urandom;
         in_wt     = wt_tab[$urandom_range(0, 6)];
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      drain(2000);

      // Reset mid-REQ with 3 commands queued
      for (int i = 0; i < 4; i++) begin
         push_item(3'($urandom), $urandom, $urandom, -1, 8);
      end
      in_valid = 1'b0;
      chk("pre_rst_req", 64'(mas_alu_req), 64'(1));
      chk("pre_rst_q_count", 64'(q_count), 64'(3));
      rst = 1'b1;
      #1;
      chk("mid_rst_req", 64'(mas_alu_req), 64'(0));
      chk("mid_rst_q_count", 64'(q_count), 64'(0));
      chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
      push_q.delete();
      exp_q.delete();
      req_cnt = 0;
      req_prev = 1'b0;
      mas_alu_ready = 1'b0;
      cyc();
      rst = 1'b0;
      push_item(3'd0, 32'd40, 32'd2, 2, 4);
      in_valid = 1'b0;
      wait_valid(20);
      chk("post_rst_res", 64'(out_res), 64'(42));
      drain(50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
